// File: rtl/ev_timer_sched_pkg.sv
// Shared types for the event-timer request scheduler and ID allocator.
package ev_timer_sched_pkg;

    typedef enum logic {
        S_INIT,
        S_RUN
    } sched_state_e;

endpackage

// File: rtl/ev_timer_sched_if.sv
// Requester-side and timer-side handshake bundle of the event-timer scheduler.
interface ev_timer_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 4
);
    localparam int REQ_IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_start_valid;
    logic [N_REQ-1:0]      req_start_ready;
    logic [ID_W-1:0]       req_start_id;
    logic [N_REQ-1:0]      req_end_valid;
    logic [N_REQ*ID_W-1:0] req_end_id;
    logic [N_REQ-1:0]      req_end_ready;
    logic                  tmr_start_valid;
    logic                  tmr_start_ready;
    logic [ID_W-1:0]       tmr_start_id;
    logic                  tmr_end_valid;
    logic                  tmr_end_ready;
    logic [ID_W-1:0]       tmr_end_id;
    logic                  init_done;
    logic [ID_W:0]         free_count;
    logic                  err_illegal_end;
    logic [REQ_IDX_W-1:0]  err_req_idx;

    modport master (
        output req_start_valid, req_end_valid, req_end_id, tmr_start_ready, tmr_end_ready,
        input  req_start_ready, req_start_id, req_end_ready, tmr_start_valid, tmr_start_id,
               tmr_end_valid, tmr_end_id, init_done, free_count, err_illegal_end, err_req_idx
    );

    modport slave (
        input  req_start_valid, req_end_valid, req_end_id, tmr_start_ready, tmr_end_ready,
        output req_start_ready, req_start_id, req_end_ready, tmr_start_valid, tmr_start_id,
               tmr_end_valid, tmr_end_id, init_done, free_count, err_illegal_end, err_req_idx
    );

endinterface

// File: rtl/ev_timer_sched_rr_arb.sv
// Round-robin arbiter: combinational scan starting at a registered pointer,
// pointer moves past the grantee whenever the grant is consumed.
module rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = IDX_W'(idx);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/ev_timer_sched.sv
// Shares the timer's start/end ports among N_REQ requesters, allocates event IDs
// from a free list and rejects ends that do not come from the ID's owner.
module ev_timer_sched
    import ev_timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 4
) (
    input logic            clk,
    input logic            rst_n,
    ev_timer_sched_if.slave bus
);
    localparam int DEPTH     = 1 << ID_W;
    localparam int REQ_IDX_W = $clog2(N_REQ);
    localparam logic [ID_W:0] FULL = (ID_W + 1)'(DEPTH);

    sched_state_e state, state_next;
    logic running, init_push, init_last;
    logic [ID_W-1:0] init_cnt;

    logic [ID_W-1:0] fifo_mem [DEPTH];
    logic [ID_W-1:0] rd_ptr, wr_ptr, push_id;
    logic [ID_W:0]   free_count;
    logic            push, pop;

    logic [DEPTH-1:0]     own_vld;
    logic [REQ_IDX_W-1:0] own_idx [DEPTH];

    logic [N_REQ-1:0]     start_gnt, end_gnt;
    logic [REQ_IDX_W-1:0] start_gnt_idx, end_gnt_idx;
    logic                 start_valid, start_fire;
    logic                 end_any, end_legal, end_valid, end_fire, end_reject, end_consume;
    logic [ID_W-1:0]      end_id;
    logic                 err_illegal_q;
    logic [REQ_IDX_W-1:0] err_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_INIT:  if (init_last) state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_INIT;
        endcase
    end

    always_comb begin
        running   = 1'b0;
        init_push = 1'b0;
        case (state)
            S_INIT:  init_push = 1'b1;
            S_RUN:   running   = 1'b1;
            default: ;
        endcase
    end

    assign init_last = (init_cnt == ID_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         init_cnt <= '0;
        else if (init_push) init_cnt <= init_cnt + 1'b1;
    end

    rr_arb #(.N(N_REQ), .IDX_W(REQ_IDX_W)) u_start_arb (
        .clk(clk), .rst_n(rst_n), .req(bus.req_start_valid), .advance(start_fire),
        .gnt(start_gnt), .gnt_idx(start_gnt_idx)
    );

    rr_arb #(.N(N_REQ), .IDX_W(REQ_IDX_W)) u_end_arb (
        .clk(clk), .rst_n(rst_n), .req(bus.req_end_valid), .advance(end_consume),
        .gnt(end_gnt), .gnt_idx(end_gnt_idx)
    );

    // Start path never looks at tmr_start_ready to form its valid.
    assign start_valid = running && (|bus.req_start_valid) && (free_count != '0);
    assign start_fire  = start_valid && bus.tmr_start_ready;

    always_comb begin
        end_id = '0;
        for (int i = 0; i < N_REQ; i++)
            if (end_gnt[i]) end_id = bus.req_end_id[i*ID_W +: ID_W];
    end

    assign end_any     = running && (|bus.req_end_valid);
    assign end_legal   = own_vld[end_id] && (own_idx[end_id] == end_gnt_idx);
    assign end_valid   = end_any && end_legal;
    assign end_fire    = end_valid && bus.tmr_end_ready;
    assign end_reject  = end_any && !end_legal;
    assign end_consume = end_fire || end_reject;

    assign push    = init_push || end_fire;
    assign push_id = init_push ? init_cnt : end_id;
    assign pop     = start_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            free_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_id;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      free_count <= free_count + 1'b1;
            else if (pop && !push) free_count <= free_count - 1'b1;
        end
    end

    // Start and end can never target the same ID in one cycle: a forwarded end's ID is owned, not free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_vld <= '0;
            for (int i = 0; i < DEPTH; i++) own_idx[i] <= '0;
        end else begin
            if (end_fire) own_vld[end_id] <= 1'b0;
            if (start_fire) begin
                own_vld[fifo_mem[rd_ptr]] <= 1'b1;
                own_idx[fifo_mem[rd_ptr]] <= start_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal_q <= 1'b0;
            err_idx_q     <= '0;
        end else begin
            err_illegal_q <= end_reject;
            if (end_reject) err_idx_q <= end_gnt_idx;
        end
    end

    assign bus.tmr_start_valid = start_valid;
    assign bus.tmr_start_id    = fifo_mem[rd_ptr];
    assign bus.req_start_id    = fifo_mem[rd_ptr];
    assign bus.req_start_ready = start_fire ? start_gnt : '0;
    assign bus.tmr_end_valid   = end_valid;
    assign bus.tmr_end_id      = running ? end_id : '0;
    assign bus.req_end_ready   = end_consume ? end_gnt : '0;
    assign bus.init_done       = running;
    assign bus.free_count      = free_count;
    assign bus.err_illegal_end = err_illegal_q;
    assign bus.err_req_idx     = err_idx_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> free_count != FULL);

endmodule
